// File: rtl/inst_buffer_pkg.sv
// Shared types and default sizing for the instruction buffer between fetch and decode.
// Holds the per-entry payload (inst/PC/NPC) and the fetch/decode widths.
package inst_buffer_pkg;

  localparam int INST_FETCH_NUM = 4;
  localparam int IB_DEPTH       = 16;
  localparam int DECODE_NUM     = 4;

  typedef struct packed {
    logic [31:0] inst;
    logic [31:0] pc;
    logic [31:0] npc;
  } ib_entry_t;

endpackage

// File: rtl/inst_buffer_stats.sv
// Occupancy statistics for inst_buffer: cycles spent full and flush cycles seen.
// Only instantiated when INST_BUFFER_STATS_EN is defined.
module inst_buffer_stats (
  input  logic        clock,
  input  logic        reset,
  input  logic        ib_full,
  input  logic        flush,
  output logic [31:0] stat_full_cycles,
  output logic [31:0] stat_flushes
);

  // Counters wrap naturally at 2^32; flush does not clear them, only reset does.
  always_ff @(posedge clock) begin
    if (reset) begin
      stat_full_cycles <= '0;
      stat_flushes     <= '0;
    end else begin
      if (ib_full) stat_full_cycles <= stat_full_cycles + 32'd1;
      if (flush)   stat_flushes     <= stat_flushes + 32'd1;
    end
  end

endmodule

// File: rtl/inst_buffer.sv
// Circular instruction queue between fetch and decode; optional statistics
// outputs are added when the INST_BUFFER_STATS_EN macro is defined.
module inst_buffer
  import inst_buffer_pkg::*;
#(
  parameter int IB_DEPTH   = inst_buffer_pkg::IB_DEPTH,
  parameter int FETCH_NUM  = inst_buffer_pkg::INST_FETCH_NUM,
  parameter int DECODE_NUM = inst_buffer_pkg::DECODE_NUM
) (
  input  logic                             clock,
  input  logic                             reset,
  input  logic                             flush,
  input  logic                             insts_in_valid,
  input  ib_entry_t [FETCH_NUM-1:0]        insts_in,
  output logic                             ib_full,
  output logic [DECODE_NUM-1:0]            insts_out_valid,
  output ib_entry_t [DECODE_NUM-1:0]       insts_out,
  input  logic                             decode_ready,
  output logic [$clog2(IB_DEPTH):0]        ib_count
`ifdef INST_BUFFER_STATS_EN
  ,
  output logic [31:0]                      stat_full_cycles,
  output logic [31:0]                      stat_flushes
`endif
);

  localparam int PTR_W = $clog2(IB_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  localparam logic [CNT_W-1:0] FULL_THRESH = CNT_W'(IB_DEPTH - FETCH_NUM);
  localparam logic [CNT_W-1:0] FETCH_CNT   = CNT_W'(FETCH_NUM);
  localparam logic [CNT_W-1:0] DECODE_CNT  = CNT_W'(DECODE_NUM);

  logic [PTR_W-1:0] head;
  logic [PTR_W-1:0] tail;
  logic [CNT_W-1:0] count;
  ib_entry_t        array [IB_DEPTH];

  logic             enq;
  logic [CNT_W-1:0] n_avail;
  logic [CNT_W-1:0] deq_n;

  // Full is decoded from registered count only, so fetch never sees a path from decode_ready.
  assign ib_full  = (count > FULL_THRESH);
  assign enq      = insts_in_valid & ~ib_full;
  assign n_avail  = (count < DECODE_CNT) ? count : DECODE_CNT;
  assign deq_n    = decode_ready ? n_avail : '0;
  assign ib_count = count;

  // NOTE: every output gets a default before the loop so no latch is inferred.
  always_comb begin
    insts_out       = '0;
    insts_out_valid = '0;
    for (int j = 0; j < DECODE_NUM; j++) begin
      if (CNT_W'(j) < n_avail) begin
        insts_out_valid[j] = 1'b1;
        insts_out[j]       = array[head + PTR_W'(j)];
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clock) begin
    if (reset || flush) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (enq) tail <= tail + PTR_W'(FETCH_NUM);
      head  <= head + PTR_W'(deq_n);
      count <= count + (enq ? FETCH_CNT : '0) - deq_n;
    end
  end

  // NOTE: the entry array is not reset; count gates every read, so stale data is never visible.
  always_ff @(posedge clock) begin
    if (enq && !flush && !reset) begin
      for (int i = 0; i < FETCH_NUM; i++) begin
        array[tail + PTR_W'(i)] <= insts_in[i];
      end
    end
  end

`ifdef INST_BUFFER_STATS_EN
  inst_buffer_stats u_stats (
    .clock            (clock),
    .reset            (reset),
    .ib_full          (ib_full),
    .flush            (flush),
    .stat_full_cycles (stat_full_cycles),
    .stat_flushes     (stat_flushes)
  );
`endif

endmodule

// File: tb/tb_inst_buffer.sv
// Directed self-checking bench for inst_buffer; covers the statistics outputs
// too when INST_BUFFER_STATS_EN is defined.
module tb_inst_buffer;
  import inst_buffer_pkg::*;

  localparam int FN = INST_FETCH_NUM;
  localparam int DN = DECODE_NUM;

  logic                   clock = 1'b0;
  logic                   reset;
  logic                   flush;
  logic                   insts_in_valid;
  ib_entry_t [FN-1:0]     insts_in;
  logic                   ib_full;
  logic [DN-1:0]          insts_out_valid;
  ib_entry_t [DN-1:0]     insts_out;
  logic                   decode_ready;
  logic [4:0]             ib_count;
`ifdef INST_BUFFER_STATS_EN
  logic [31:0]            stat_full_cycles;
  logic [31:0]            stat_flushes;
`endif

  int tests_run = 0;
  int tests_failed = 0;

  inst_buffer dut (
    .clock           (clock),
    .reset           (reset),
    .flush           (flush),
    .insts_in_valid  (insts_in_valid),
    .insts_in        (insts_in),
    .ib_full         (ib_full),
    .insts_out_valid (insts_out_valid),
    .insts_out       (insts_out),
    .decode_ready    (decode_ready),
    .ib_count        (ib_count)
`ifdef INST_BUFFER_STATS_EN
    ,
    .stat_full_cycles(stat_full_cycles),
    .stat_flushes    (stat_flushes)
`endif
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [63:0] actual, input logic [63:0] expected);
    tests_run++;
    if (actual !== expected) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, actual, expected);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  // Pack of four consecutive PCs starting at base; inst tagged so field swaps are visible.
  task automatic set_pack(input logic [31:0] base);
    for (int i = 0; i < FN; i++) begin
      insts_in[i].pc   = base + 32'(4 * i);
      insts_in[i].npc  = base + 32'(4 * i) + 32'd4;
      insts_in[i].inst = (base + 32'(4 * i)) ^ 32'hA5A5_0000;
    end
  endtask

  initial begin
    int m_count;
    int sent;
    int n;
    logic [31:0] exp_pc;
    logic        v;

    reset = 1'b1; flush = 1'b0; insts_in_valid = 1'b0; decode_ready = 1'b0;
    insts_in = '0;
    step(); step();
    check("rst_count", 64'(ib_count), 64'd0);
    check("rst_full", 64'(ib_full), 64'd0);
    check("rst_valid", 64'(insts_out_valid), 64'd0);
    check("rst_out", 64'(insts_out[0].pc | insts_out[3].inst), 64'd0);
`ifdef INST_BUFFER_STATS_EN
    check("rst_stat_full", 64'(stat_full_cycles), 64'd0);
    check("rst_stat_flush", 64'(stat_flushes), 64'd0);
`endif
    reset = 1'b0;

    // One pack, decode always ready.
    set_pack(32'h0); insts_in_valid = 1'b1; decode_ready = 1'b1;
    step();
    insts_in_valid = 1'b0;
    check("p1_count", 64'(ib_count), 64'd4);
    check("p1_valid", 64'(insts_out_valid), 64'hF);
    for (int j = 0; j < DN; j++) check($sformatf("p1_pc%0d", j), 64'(insts_out[j].pc), 64'(4 * j));
    check("p1_npc3", 64'(insts_out[3].npc), 64'h10);
    check("p1_inst1", 64'(insts_out[1].inst), 64'hA5A5_0004);
    step();
    check("p1_drain_valid", 64'(insts_out_valid), 64'd0);
    check("p1_drain_count", 64'(ib_count), 64'd0);
    step();
    check("empty_ready_count", 64'(ib_count), 64'd0);

    // Fill to full without decode.
    decode_ready = 1'b0;
    for (int k = 0; k < 4; k++) begin
      set_pack(32'h100 + 32'(16 * k)); insts_in_valid = 1'b1;
      step();
      check($sformatf("fill_count%0d", k), 64'(ib_count), 64'(4 * (k + 1)));
      check($sformatf("fill_full%0d", k), 64'(ib_full), (k == 3) ? 64'd1 : 64'd0);
    end
    set_pack(32'h140);
    step();
    check("ignored_count", 64'(ib_count), 64'd16);
    check("ignored_head", 64'(insts_out[0].pc), 64'h100);

    // Drain from full with the stalled pack still held.
    decode_ready = 1'b1;
    step();
    check("drain1_count", 64'(ib_count), 64'd12);
    check("drain1_full", 64'(ib_full), 64'd0);
    check("drain1_pc0", 64'(insts_out[0].pc), 64'h110);
    step();
    insts_in_valid = 1'b0;
    check("enqdeq_count", 64'(ib_count), 64'd12);
    check("enqdeq_pc0", 64'(insts_out[0].pc), 64'h120);
    check("enqdeq_pc3", 64'(insts_out[3].pc), 64'h12C);
    step();
    check("drain3_pc0", 64'(insts_out[0].pc), 64'h130);
    step();
    check("drain4_pc0", 64'(insts_out[0].pc), 64'h140);
    check("drain4_pc3", 64'(insts_out[3].pc), 64'h14C);
    check("drain4_count", 64'(ib_count), 64'd4);
    step();
    check("drain5_count", 64'(ib_count), 64'd0);

    // Six packs with decode_ready pulsed; tail and head cross the wrap point.
    m_count = 0; sent = 0; exp_pc = 32'h300;
    for (int c = 0; c < 60 && (sent < 6 || m_count > 0); c++) begin
      decode_ready = ((c % 3) != 0);
      v = (sent < 6);
      insts_in_valid = v;
      if (v) set_pack(32'h300 + 32'(16 * sent));
      n = (m_count < DN) ? m_count : DN;
      check($sformatf("wrap_count_c%0d", c), 64'(ib_count), 64'(m_count));
      check($sformatf("wrap_full_c%0d", c), 64'(ib_full), (m_count > 12) ? 64'd1 : 64'd0);
      check($sformatf("wrap_valid_c%0d", c), 64'(insts_out_valid), 64'((1 << n) - 1));
      for (int j = 0; j < n; j++)
        check($sformatf("wrap_pc_c%0d_s%0d", c, j), 64'(insts_out[j].pc), 64'(exp_pc + 32'(4 * j)));
      step();
      if (v && !(m_count > 12)) begin
        sent++;
        m_count += 4;
      end
      if (decode_ready) begin
        exp_pc += 32'(4 * n);
        m_count -= n;
      end
    end
    insts_in_valid = 1'b0;
    check("wrap_all_sent", 64'(sent), 64'd6);
    check("wrap_last_pc", 64'(exp_pc), 64'h360);

    // Flush with a pack and decode_ready in the same cycle.
    decode_ready = 1'b0;
    set_pack(32'h500); insts_in_valid = 1'b1; step();
    set_pack(32'h510); step();
    check("pre_flush_count", 64'(ib_count), 64'd8);
    set_pack(32'h600); flush = 1'b1; decode_ready = 1'b1;
    step();
    flush = 1'b0; insts_in_valid = 1'b0;
    check("flush_count", 64'(ib_count), 64'd0);
    check("flush_valid", 64'(insts_out_valid), 64'd0);
    check("flush_full", 64'(ib_full), 64'd0);
    step();
    check("flush_dropped", 64'(insts_out_valid), 64'd0);
    decode_ready = 1'b0;
    set_pack(32'h700); insts_in_valid = 1'b1; step();
    insts_in_valid = 1'b0;
    check("post_flush_pc0", 64'(insts_out[0].pc), 64'h700);
    check("post_flush_count", 64'(ib_count), 64'd4);

    // Reset and flush together.
    reset = 1'b1; flush = 1'b1; step();
    reset = 1'b0; flush = 1'b0;
    check("rstflush_count", 64'(ib_count), 64'd0);
    check("rstflush_valid", 64'(insts_out_valid), 64'd0);

`ifdef INST_BUFFER_STATS_EN
    check("stat0_full", 64'(stat_full_cycles), 64'd0);
    check("stat0_flush", 64'(stat_flushes), 64'd0);
    for (int k = 0; k < 4; k++) begin
      set_pack(32'h800 + 32'(16 * k)); insts_in_valid = 1'b1; step();
    end
    insts_in_valid = 1'b0;
    step(); step();
    decode_ready = 1'b1; step();
    decode_ready = 1'b0;
    flush = 1'b1; step(); step();
    flush = 1'b0;
    check("stat_full_cycles", 64'(stat_full_cycles), 64'd3);
    check("stat_flushes", 64'(stat_flushes), 64'd2);
    reset = 1'b1; step();
    reset = 1'b0;
    check("stat_rst_full", 64'(stat_full_cycles), 64'd0);
    check("stat_rst_flush", 64'(stat_flushes), 64'd0);
`endif

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
